// File: rtl/processor_defines.sv
// Shared processor definitions: memory FSM states, access modes and request payload.
package processor_defines;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned WIDX_W = 30;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Request latched on accept and held until the response cycle.
    typedef struct packed {
        logic              rw;
        logic [WIDX_W-1:0] widx;
        logic [WORD_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } mem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage with per-byte-lane writes and a combinational read port.
module dmem_array
    import processor_defines::*;
#(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [STRB_W-1:0] strb,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];

    // Merge the strobed byte lanes of the write data into the addressed word.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (strb[b]) begin
                    mem_d[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    // Storage register; reset clears every word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Fixed-latency data memory controller: accepts one request at a time, responds LATENCY cycles later.
module data_mem_ctrl
    import processor_defines::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              req_valid,
    input  logic              mem_rw_mode,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_strb,
    output logic [31:0]       mem_data,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_req_t          req_q, req_d;
    logic [WORD_W-1:0] mem_data_q, mem_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;

    logic              enter_resp_c;
    logic              in_range_c;
    logic              arr_we_c;
    logic [IDX_W-1:0]  arr_idx_c;
    logic [WORD_W-1:0] arr_rdata;
    logic              addr_lsb_unused_c;

    // Byte offset is resolved by the load stage, not here.
    assign addr_lsb_unused_c = ^mem_addr[1:0];

    // Next-state, latency counter and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.rw    = mem_rw_mode;
                    req_d.widx  = mem_addr[31:2];
                    req_d.wdata = wr_data;
                    req_d.strb  = wr_strb;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The request commits on the edge entering RESP; req_d covers the LATENCY=1 bypass.
    assign enter_resp_c = (state_d == RESP);
    assign in_range_c   = (req_d.widx < WIDX_W'(DEPTH));
    assign arr_idx_c    = IDX_W'(req_d.widx);
    assign arr_we_c     = enter_resp_c && in_range_c && (req_d.rw == MEM_WRITE);

    // Response outputs; read data only changes on a read response.
    always_comb begin
        mem_data_d  = mem_data_q;
        rsp_valid_d = enter_resp_c;
        rsp_err_d   = enter_resp_c && !in_range_c;
        busy_d      = (state_d != IDLE);
        if (enter_resp_c && (req_d.rw == MEM_READ)) begin
            mem_data_d = in_range_c ? arr_rdata : '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            mem_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            mem_data_q  <= mem_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_dmem_array (
        .clk   (i_clk),
        .rst   (i_rst),
        .we    (arr_we_c),
        .strb  (req_d.strb),
        .idx   (arr_idx_c),
        .wdata (req_d.wdata),
        .rdata (arr_rdata)
    );

    assign mem_data  = mem_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: a LATENCY=3 and a LATENCY=1 controller share one stimulus stream.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;

    logic [31:0] md3, md1;
    logic        rv3, rv1, re3, re1, bz3, bz1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(256), .LATENCY(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .req_valid(req_valid), .mem_rw_mode(rw),
        .mem_addr(addr), .wr_data(wdata), .wr_strb(strb),
        .mem_data(md3), .rsp_valid(rv3), .rsp_err(re3), .busy(bz3)
    );

    data_mem_ctrl #(.DEPTH(256), .LATENCY(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .req_valid(req_valid), .mem_rw_mode(rw),
        .mem_addr(addr), .wr_data(wdata), .wr_strb(strb),
        .mem_data(md1), .rsp_valid(rv1), .rsp_err(re1), .busy(bz1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait (bounded) for the chosen instance's response, then one idle cycle.
    task automatic do_req(input int u, input logic r, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output logic err, output logic [31:0] md);
        req_valid = 1'b1; rw = r; addr = a; wdata = d; strb = s;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!((u == 1) ? rv1 : rv3) && lat < 12) begin
            tick();
            lat++;
        end
        err = (u == 1) ? re1 : re3;
        md  = (u == 1) ? md1 : md3;
        tick();
    endtask

    task automatic drain3();
        int n = 0;
        while (bz3 && n < 12) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(bz3), 32'd0);
    endtask

    initial begin
        int          lat;
        logic        err;
        logic [31:0] md;
        logic [9:0]  busy_v, rsp_v;
        logic [7:0]  busy1_v, rsp1_v;
        int          seen;

        // Reset asserted together with a request: reset wins.
        rst = 1'b1; req_valid = 1'b1; rw = 1'b1; addr = 32'h10; wdata = 32'hFFFF_FFFF; strb = 4'hF;
        tick();
        tick();
        rst = 1'b0; req_valid = 1'b0;
        check("rst_busy", 32'(bz3), 32'd0);
        check("rst_rsp_valid", 32'(rv3), 32'd0);
        check("rst_rsp_err", 32'(re3), 32'd0);
        check("rst_mem_data", md3, 32'd0);
        tick();
        check("rst_no_accept", 32'(bz3), 32'd0);

        // Full-word write then read at a misaligned byte address of the same word.
        do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, err, md);
        check("wr_latency", 32'(lat), 32'd3);
        check("wr_err", 32'(err), 32'd0);
        check("wr_md_unchanged", md, 32'd0);
        check("rsp_pulse_end", 32'(rv3), 32'd0);
        check("busy_end", 32'(bz3), 32'd0);
        do_req(0, 1'b0, 32'h12, 32'h0, 4'h0, lat, err, md);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_data", md, 32'hDEAD_BEEF);
        check("rd_err", 32'(err), 32'd0);

        // Single-lane write and an all-lanes-disabled write.
        do_req(0, 1'b1, 32'h10, 32'h0000_00AA, 4'h1, lat, err, md);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, err, md);
        check("strb1_data", md, 32'hDEAD_BEAA);
        do_req(0, 1'b1, 32'h10, 32'h1122_3344, 4'h0, lat, err, md);
        do_req(0, 1'b0, 32'h11, 32'h0, 4'h0, lat, err, md);
        check("strb0_noop", md, 32'hDEAD_BEAA);
        do_req(0, 1'b1, 32'h10, 32'h7700_0000, 4'h8, lat, err, md);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, err, md);
        check("strb8_data", md, 32'h77AD_BEAA);

        // Out-of-range read and write; index 256 must not alias onto word 0.
        do_req(0, 1'b0, 32'h400, 32'h0, 4'h0, lat, err, md);
        check("oor_rd_err", 32'(err), 32'd1);
        check("oor_rd_data", md, 32'd0);
        check("oor_rd_latency", 32'(lat), 32'd3);
        do_req(0, 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, lat, err, md);
        check("oor_wr_err", 32'(err), 32'd1);
        check("oor_wr_md_hold", md, 32'd0);
        check("err_cleared", 32'(re3), 32'd0);
        do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, err, md);
        check("oor_no_alias", md, 32'd0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, err, md);
        check("oor_word10_kept", md, 32'h77AD_BEAA);
        do_req(0, 1'b0, 32'h3FC, 32'h0, 4'h0, lat, err, md);
        check("last_word_err", 32'(err), 32'd0);

        // req_valid held for 10 cycles: accept every fourth edge.
        req_valid = 1'b1; rw = 1'b0; addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            tick();
            busy_v[i] = bz3;
            rsp_v[i]  = rv3;
        end
        req_valid = 1'b0;
        check("hold_busy_pattern", 32'(busy_v), 32'(10'b11_0111_0111));
        check("hold_rsp_pattern", 32'(rsp_v), 32'(10'b00_0100_0100));
        drain3();
        tick();

        // Reset one cycle after accepting a write aborts it.
        req_valid = 1'b1; rw = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; strb = 4'hF;
        tick();
        req_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bz3), 32'd0);
        check("abort_rsp", 32'(rv3), 32'd0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rv3) seen++;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, err, md);
        check("abort_no_commit", md, 32'd0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, err, md);
        check("rst_cleared_array", md, 32'd0);

        // LATENCY=1 instance: back-to-back reads respond every second cycle.
        do_req(0, 1'b1, 32'h8, 32'h5A5A_1234, 4'hF, lat, err, md);
        req_valid = 1'b1; rw = 1'b0; addr = 32'h8;
        for (int i = 0; i < 8; i++) begin
            tick();
            busy1_v[i] = bz1;
            rsp1_v[i]  = rv1;
        end
        req_valid = 1'b0;
        check("l1_rsp_pattern", 32'(rsp1_v), 32'(8'b0101_0101));
        check("l1_busy_pattern", 32'(busy1_v), 32'(8'b0101_0101));
        check("l1_data", md1, 32'h5A5A_1234);
        drain3();
        do_req(1, 1'b0, 32'h400, 32'h0, 4'h0, lat, err, md);
        check("l1_latency", 32'(lat), 32'd1);
        check("l1_oor_err", 32'(err), 32'd1);
        check("l1_oor_data", md, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
